isa_port_scheduler: RTL and testbench

On-chip scheduler that shares the single off-chip port between OPNUM configuration requesters (ISA fetch) and one data-transfer requester.
- Grants ISA fetch requests round-robin and issues a fetch command carrying the per-op ISA pointer, length and op index.
- Steers returned ISA words to the granted op, counts them, then advances that op's pointer.
- Data requests pass a command verbatim, count beats and control port direction.

---
 rtl/isa_port_scheduler.sv | 279 +++++++++++++++++++++++++++
 tb/tb_isa_port_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isa_port_scheduler.sv
// -----------------------------------------------------------------------------
// isa_port_scheduler
//
// Shares the single off-chip port between OPNUM ISA-fetch requesters and one
// data-transfer requester.
//
//  * ISA fetches are granted round-robin. The granted op gets a fetch command
//    carrying its ISA pointer, burst length and op index. The returned words
//    are steered to that op and counted. When the burst completes, the op's
//    pointer advances by the burst length.
//  * A data request passes its command word through unchanged. Its beats are
//    counted, and the port direction follows the request's write flag.
//
// Ports
//   clk, rst_n             clock; reset is asynchronous and active-high
//   cfg_base / cfg_num     per-op ISA base address / words per fetch (packed)
//   base_load              reload every pointer from cfg_base
//   cfg_req / isa_rdy      per-op fetch request / per-op word-accept ready
//   isa_vld / isa_idx      word valid toward the granted op / granted index
//   dat_req/wr/len/cmd     data-transfer request and its parameters
//   dat_ack / dat_done     request accepted / last beat done (pulses)
//   dat_beat               data-phase port handshake
//   cmd_vld/cmd_dat/cmd_rdy  command channel to the off-chip side
//   rx_vld / rx_rdy        ISA word return channel
//   port_oe                chip drives the port
//   busy                   scheduler not idle
// -----------------------------------------------------------------------------
module isa_port_scheduler #(
   parameter int OPNUM      = 6,
   parameter int ADDR_WIDTH = 16,
   parameter int LEN_WIDTH  = 8,
   parameter int PORT_WIDTH = 128,
   localparam int IDX_W     = (OPNUM > 1) ? $clog2(OPNUM) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [OPNUM*ADDR_WIDTH-1:0]   cfg_base,
   input  logic [OPNUM*LEN_WIDTH-1:0]    cfg_num,
   input  logic                          base_load,
   input  logic [OPNUM-1:0]              cfg_req,
   input  logic [OPNUM-1:0]              isa_rdy,
   output logic                          isa_vld,
   output logic [IDX_W-1:0]              isa_idx,
   input  logic                          dat_req,
   input  logic                          dat_wr,
   input  logic [LEN_WIDTH-1:0]          dat_len,
   input  logic [PORT_WIDTH-1:0]         dat_cmd,
   output logic                          dat_ack,
   output logic                          dat_done,
   input  logic                          dat_beat,
   output logic                          cmd_vld,
   output logic [PORT_WIDTH-1:0]         cmd_dat,
   input  logic                          cmd_rdy,
   input  logic                          rx_vld,
   output logic                          rx_rdy,
   output logic                          port_oe,
   output logic                          busy
);

   typedef enum logic [2:0] {
      IDLE,
      ISA_CMD,
      ISA_RX,
      DAT_CMD,
      DAT_XFER
   } state_t;

   localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);
   localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(1);
   localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(OPNUM - 1);
   localparam int                   LEN_LSB   = 1 + ADDR_WIDTH;
   localparam int                   IDX_LSB   = 1 + ADDR_WIDTH + LEN_WIDTH;

   state_t                  state_reg, state_next;
   logic [IDX_W-1:0]        grant_reg, grant_next;
   logic [IDX_W-1:0]        rr_reg, rr_next;
   logic [LEN_WIDTH-1:0]    len_reg, len_next;
   logic [LEN_WIDTH-1:0]    cnt_reg, cnt_next;
   logic                    wr_reg, wr_next;
   logic [PORT_WIDTH-1:0]   cmd_reg, cmd_next;
   logic [ADDR_WIDTH-1:0]   ptr_reg [OPNUM];

   logic [ADDR_WIDTH-1:0]   base_arr [OPNUM];
   logic [LEN_WIDTH-1:0]    num_arr  [OPNUM];
   logic [OPNUM-1:0]        eligible;
   logic [IDX_W-1:0]        grant_sel;
   logic                    grant_found;
   logic [IDX_W:0]          cand;
   logic [PORT_WIDTH-1:0]   isa_word;
   logic                    fetch_done;

   // Combinational output values before the reset gate
   logic                    isa_vld_c, dat_ack_c, dat_done_c, cmd_vld_c;
   logic                    rx_rdy_c, port_oe_c;
   logic [IDX_W-1:0]        isa_idx_c;
   logic [PORT_WIDTH-1:0]   cmd_dat_c;

   // Unpack per-op configuration; a zero-length op can never be granted.
   genvar gi;
   generate
      for (gi = 0; gi < OPNUM; gi++) begin : g_cfg
         assign base_arr[gi] = cfg_base[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign num_arr[gi]  = cfg_num[gi*LEN_WIDTH +: LEN_WIDTH];
         assign eligible[gi] = cfg_req[gi] && (num_arr[gi] != '0);
      end
   endgenerate

   // Round-robin search starting at rr_reg. Walk offsets from high to low so
   // the smallest offset (closest to rr_reg) is the last assignment and wins.
   always_comb begin
      grant_found = 1'b0;
      grant_sel   = '0;
      cand        = '0;
      for (int k = OPNUM - 1; k >= 0; k--) begin
         cand = {1'b0, rr_reg} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(OPNUM)) begin
            cand = cand - (IDX_W+1)'(OPNUM);
         end
         if (eligible[cand[IDX_W-1:0]]) begin
            grant_found = 1'b1;
            grant_sel   = cand[IDX_W-1:0];
         end
      end
   end

   // Fetch command for the candidate grant, built at grant time so the word
   // stays stable through ISA_CMD even if the pointers are reloaded meanwhile.
   always_comb begin
      isa_word                        = '0;
      isa_word[1 +: ADDR_WIDTH]       = ptr_reg[grant_sel];
      isa_word[LEN_LSB +: LEN_WIDTH]  = num_arr[grant_sel];
      isa_word[IDX_LSB +: IDX_W]      = grant_sel;
   end

   // Next-state and output logic
   always_comb begin
      state_next  = state_reg;
      grant_next  = grant_reg;
      rr_next     = rr_reg;
      len_next    = len_reg;
      cnt_next    = cnt_reg;
      wr_next     = wr_reg;
      cmd_next    = cmd_reg;
      fetch_done  = 1'b0;
      isa_vld_c   = 1'b0;
      isa_idx_c   = '0;
      dat_ack_c   = 1'b0;
      dat_done_c  = 1'b0;
      cmd_vld_c   = 1'b0;
      cmd_dat_c   = '0;
      rx_rdy_c    = 1'b0;
      port_oe_c   = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (dat_req) begin
               dat_ack_c = 1'b1;
               if (dat_len == '0) begin
                  dat_done_c = 1'b1;
               end else begin
                  len_next   = dat_len;
                  wr_next    = dat_wr;
                  cmd_next   = dat_cmd;
                  cnt_next   = '0;
                  state_next = DAT_CMD;
               end
            end else if (grant_found) begin
               grant_next = grant_sel;
               len_next   = num_arr[grant_sel];
               cmd_next   = isa_word;
               cnt_next   = '0;
               state_next = ISA_CMD;
            end
         end

         ISA_CMD: begin
            cmd_vld_c = 1'b1;
            cmd_dat_c = cmd_reg;
            port_oe_c = 1'b1;
            isa_idx_c = grant_reg;
            if (cmd_rdy) begin
               cnt_next   = '0;
               state_next = ISA_RX;
            end
         end

         ISA_RX: begin
            rx_rdy_c  = isa_rdy[grant_reg];
            isa_vld_c = rx_vld;
            isa_idx_c = grant_reg;
            if (rx_vld && isa_rdy[grant_reg]) begin
               if (cnt_reg == len_reg - LEN_ONE) begin
                  fetch_done = 1'b1;
                  rr_next    = (grant_reg == IDX_LAST) ? '0 : grant_reg + IDX_ONE;
                  state_next = IDLE;
               end else begin
                  cnt_next = cnt_reg + LEN_ONE;
               end
            end
         end

         DAT_CMD: begin
            cmd_vld_c = 1'b1;
            cmd_dat_c = cmd_reg;
            port_oe_c = 1'b1;
            if (cmd_rdy) begin
               cnt_next   = '0;
               state_next = DAT_XFER;
            end
         end

         DAT_XFER: begin
            port_oe_c = wr_reg;
            if (dat_beat) begin
               if (cnt_reg == len_reg - LEN_ONE) begin
                  dat_done_c = 1'b1;
                  state_next = IDLE;
               end else begin
                  cnt_next = cnt_reg + LEN_ONE;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Control state
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_reg <= IDLE;
         grant_reg <= '0;
         rr_reg    <= '0;
         len_reg   <= '0;
         cnt_reg   <= '0;
         wr_reg    <= 1'b0;
         cmd_reg   <= '0;
      end else begin
         state_reg <= state_next;
         grant_reg <= grant_next;
         rr_reg    <= rr_next;
         len_reg   <= len_next;
         cnt_reg   <= cnt_next;
         wr_reg    <= wr_next;
         cmd_reg   <= cmd_next;
      end
   end

   // ISA pointers. A reload takes priority over a completing fetch's advance.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int i = 0; i < OPNUM; i++) begin
            ptr_reg[i] <= '0;
         end
      end else if (base_load) begin
         for (int i = 0; i < OPNUM; i++) begin
            ptr_reg[i] <= base_arr[i];
         end
      end else if (fetch_done) begin
         ptr_reg[grant_reg] <= ptr_reg[grant_reg] + ADDR_WIDTH'(len_reg);
      end
   end

   // Several outputs follow live inputs combinationally (e.g. dat_ack from
   // dat_req). They are forced low while reset is held, so nothing leaks out
   // during reset.
   assign isa_vld  = isa_vld_c  & ~rst_n;
   assign isa_idx  = rst_n ? '0 : isa_idx_c;
   assign dat_ack  = dat_ack_c  & ~rst_n;
   assign dat_done = dat_done_c & ~rst_n;
   assign cmd_vld  = cmd_vld_c  & ~rst_n;
   assign cmd_dat  = rst_n ? '0 : cmd_dat_c;
   assign rx_rdy   = rx_rdy_c   & ~rst_n;
   assign port_oe  = port_oe_c  & ~rst_n;
   assign busy     = (state_reg != IDLE) & ~rst_n;

endmodule

// File: tb/tb_isa_port_scheduler.sv
// -----------------------------------------------------------------------------
// tb_isa_port_scheduler
//
// Self-checking bench for isa_port_scheduler. Expected command words go into
// a queue when a transaction is set up. They are popped and compared when the
// DUT presents the command. Inputs are driven just after the falling edge, and
// outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_isa_port_scheduler;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [95:0]   cfg_base;
   logic [47:0]   cfg_num;
   logic          base_load;
   logic [5:0]    cfg_req;
   logic [5:0]    isa_rdy;
   logic          isa_vld;
   logic [2:0]    isa_idx;
   logic          dat_req;
   logic          dat_wr;
   logic [7:0]    dat_len;
   logic [127:0]  dat_cmd;
   logic          dat_ack;
   logic          dat_done;
   logic          dat_beat;
   logic          cmd_vld;
   logic [127:0]  cmd_dat;
   logic          cmd_rdy;
   logic          rx_vld;
   logic          rx_rdy;
   logic          port_oe;
   logic          busy;

   logic [15:0]   base [6];
   logic [7:0]    num  [6];

   int            checks   = 0;
   int            failures = 0;
   logic [127:0]  exp_q [$];

   always #5 clk = ~clk;

   always_comb begin
      cfg_base = '0;
      cfg_num  = '0;
      for (int i = 0; i < 6; i++) begin
         cfg_base[i*16 +: 16] = base[i];
         cfg_num[i*8 +: 8]    = num[i];
      end
   end

   isa_port_scheduler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_base  (cfg_base),
      .cfg_num   (cfg_num),
      .base_load (base_load),
      .cfg_req   (cfg_req),
      .isa_rdy   (isa_rdy),
      .isa_vld   (isa_vld),
      .isa_idx   (isa_idx),
      .dat_req   (dat_req),
      .dat_wr    (dat_wr),
      .dat_len   (dat_len),
      .dat_cmd   (dat_cmd),
      .dat_ack   (dat_ack),
      .dat_done  (dat_done),
      .dat_beat  (dat_beat),
      .cmd_vld   (cmd_vld),
      .cmd_dat   (cmd_dat),
      .cmd_rdy   (cmd_rdy),
      .rx_vld    (rx_vld),
      .rx_rdy    (rx_rdy),
      .port_oe   (port_oe),
      .busy      (busy)
   );

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected fetch command: bit0=0, [16:1]=ptr, [24:17]=len, [27:25]=op
   function automatic logic [127:0] isa_word(input int op, input logic [15:0] p, input logic [7:0] n);
      logic [127:0] w;
      logic [2:0]   o;
      w       = '0;
      o       = 3'(op);
      w[16:1] = p;
      w[24:17] = n;
      w[27:25] = o;
      return w;
   endfunction

   task automatic load_bases();
      @(negedge clk);
      base_load = 1'b1;
      @(negedge clk);
      base_load = 1'b0;
      #1;
   endtask

   // One complete ISA fetch: wait for the command, optionally stall cmd_rdy,
   // accept it, then return 'len' words with an optional 3-cycle isa_rdy gap
   // once gap_at words have arrived. cfg_req becomes req_after when the
   // command is accepted.
   task automatic serve_isa(input int op, input logic [15:0] ptr, input logic [7:0] len,
                            input int cmd_stall, input int gap_at, input logic [5:0] req_after);
      logic [127:0] first;
      logic [127:0] exp;
      bit           found;
      int           words;
      int           gap;
      exp_q.push_back(isa_word(op, ptr, len));
      found = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         #1;
         if (cmd_vld) begin
            found = 1'b1;
            break;
         end
      end
      check_val("isa_cmd_seen", 128'(found), 128'(1));
      if (!found) begin
         exp = exp_q.pop_front();
         return;
      end
      check_val("isa_cmd_oe", 128'(port_oe), 128'(1));
      check_val("isa_cmd_idx", 128'(isa_idx), 128'(op));
      first = cmd_dat;
      for (int s = 0; s < cmd_stall; s++) begin
         @(negedge clk);
         #1;
         check_val("cmd_stable", cmd_dat, first);
         check_val("cmd_vld_hold", 128'(cmd_vld), 128'(1));
      end
      cmd_rdy = 1'b1;
      #1;
      exp = exp_q.pop_front();
      check_val("isa_cmd_word", cmd_dat, exp);
      $display("isa fetch op=%0d cmd=%0h", op, cmd_dat);
      @(negedge clk);
      cmd_rdy = 1'b0;
      cfg_req = req_after;
      words   = 0;
      gap     = 0;
      for (int t = 0; t < 300 && words < int'(len); t++) begin
         rx_vld  = 1'b1;
         isa_rdy = '1;
         if (words == gap_at && gap < 3) begin
            isa_rdy[op] = 1'b0;
         end
         #1;
         if (!isa_rdy[op]) begin
            gap++;
            check_val("rx_rdy_stall", 128'(rx_rdy), 128'(0));
         end else begin
            check_val("rx_rdy", 128'(rx_rdy), 128'(1));
            check_val("isa_vld", 128'(isa_vld), 128'(1));
            check_val("isa_rx_idx", 128'(isa_idx), 128'(op));
            if (rx_rdy) begin
               words++;
            end
         end
         @(negedge clk);
      end
      isa_rdy = '1;
      #1;
      check_val("isa_words", 128'(words), 128'(len));
      check_val("isa_end_idle", 128'(busy), 128'(0));
      check_val("isa_no_extra", 128'(rx_rdy), 128'(0));
      rx_vld = 1'b0;
      #1;
   endtask

   // One data transfer; cfg_req is set to req_with in the same cycle as dat_req.
   task automatic serve_dat(input logic [7:0] len, input logic wr, input logic [127:0] cmd,
                            input logic [5:0] req_with);
      logic [127:0] exp;
      @(negedge clk);
      dat_req = 1'b1;
      dat_len = len;
      dat_wr  = wr;
      dat_cmd = cmd;
      cfg_req = req_with;
      #1;
      check_val("dat_ack", 128'(dat_ack), 128'(1));
      check_val("dat_done_zero", 128'(dat_done), 128'(len == 0));
      if (len != 0) begin
         exp_q.push_back(cmd);
      end
      @(negedge clk);
      dat_req = 1'b0;
      dat_len = '0;
      dat_wr  = ~wr;
      dat_cmd = '0;
      #1;
      if (len == 0) begin
         check_val("dat_zero_idle", 128'(busy), 128'(0));
         $display("dat zero-length request");
         return;
      end
      check_val("dat_cmd_vld", 128'(cmd_vld), 128'(1));
      check_val("dat_cmd_oe", 128'(port_oe), 128'(1));
      cmd_rdy = 1'b1;
      #1;
      exp = exp_q.pop_front();
      check_val("dat_cmd_word", cmd_dat, exp);
      @(negedge clk);
      cmd_rdy = 1'b0;
      for (int i = 0; i < int'(len); i++) begin
         dat_beat = 1'b1;
         #1;
         check_val("dat_oe", 128'(port_oe), 128'(wr));
         check_val("dat_done", 128'(dat_done), 128'(i == int'(len) - 1));
         @(negedge clk);
      end
      dat_beat = 1'b0;
      #1;
      check_val("dat_idle", 128'(busy), 128'(0));
      $display("dat transfer len=%0d wr=%0d cmd=%0h", len, wr, cmd);
   endtask

   initial begin
      logic [127:0] exp;
      bit           found;

      rst_n     = 1'b1;
      base_load = 1'b0;
      cfg_req   = '0;
      isa_rdy   = '1;
      dat_req   = 1'b0;
      dat_wr    = 1'b0;
      dat_len   = '0;
      dat_cmd   = '0;
      dat_beat  = 1'b0;
      cmd_rdy   = 1'b0;
      rx_vld    = 1'b0;
      base[0] = 16'd0;  base[1] = 16'd1;  base[2] = 16'd17;
      base[3] = 16'd19; base[4] = 16'd22; base[5] = 16'd28;
      num[0]  = 8'd1;   num[1]  = 8'd16;  num[2]  = 8'd2;
      num[3]  = 8'd3;   num[4]  = 8'd6;   num[5]  = 8'd2;

      // Reset: outputs stay low even with live requests
      repeat (3) @(negedge clk);
      dat_req = 1'b1;
      dat_len = 8'd4;
      cfg_req = '1;
      rx_vld  = 1'b1;
      #1;
      check_val("rst_dat_ack", 128'(dat_ack), 128'(0));
      check_val("rst_cmd_vld", 128'(cmd_vld), 128'(0));
      check_val("rst_cmd_dat", cmd_dat, 128'(0));
      check_val("rst_busy", 128'(busy), 128'(0));
      check_val("rst_port_oe", 128'(port_oe), 128'(0));
      check_val("rst_isa_vld", 128'(isa_vld), 128'(0));
      $display("reset state checked");
      dat_req = 1'b0;
      dat_len = '0;
      cfg_req = '0;
      rx_vld  = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;

      // Bases loaded; ops 2 and 5 request
      load_bases();
      cfg_req = 6'b100100;
      serve_isa(2, 16'd17, 8'd2, 0, -1, 6'b100100);
      serve_isa(5, 16'd28, 8'd2, 0, -1, 6'b000000);

      // All request: full round-robin, stall inside the 16-word op1 burst
      cfg_req = 6'b111111;
      serve_isa(0, 16'd0,  8'd1,  0, -1, 6'b111111);
      serve_isa(1, 16'd1,  8'd16, 0,  5, 6'b111111);
      serve_isa(2, 16'd19, 8'd2,  0, -1, 6'b111111);
      serve_isa(3, 16'd19, 8'd3,  0, -1, 6'b111111);
      serve_isa(4, 16'd22, 8'd6,  0, -1, 6'b111111);
      serve_isa(5, 16'd30, 8'd2,  0, -1, 6'b111111);
      serve_isa(0, 16'd1,  8'd1,  0, -1, 6'b000000);

      // Data and op0 together: data first, then op0
      serve_dat(8'd4, 1'b1, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3211, 6'b000001);
      serve_isa(0, 16'd2, 8'd1, 0, -1, 6'b000000);
      serve_dat(8'd0, 1'b0, 128'h55, 6'b000000);
      serve_dat(8'd2, 1'b0, 128'hdead_beef_0000_0001, 6'b000000);

      // Pointer wrap, command stall, zero-length requester never granted
      base[3] = 16'hFFFF;
      num[3]  = 8'd2;
      num[4]  = 8'd0;
      load_bases();
      cfg_req = 6'b011000;
      serve_isa(3, 16'hFFFF, 8'd2, 5, -1, 6'b011000);
      serve_isa(3, 16'h0001, 8'd2, 0, -1, 6'b010000);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         check_val("num0_no_grant", 128'(busy), 128'(0));
      end
      $display("zero-length requester ignored");
      cfg_req = '0;

      // Reset in the middle of an ISA burst
      cfg_req = 6'b000100;
      exp_q.push_back(isa_word(2, 16'd17, 8'd2));
      found = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         #1;
         if (cmd_vld) begin
            found = 1'b1;
            break;
         end
      end
      check_val("abort_cmd_seen", 128'(found), 128'(1));
      cmd_rdy = 1'b1;
      #1;
      exp = exp_q.pop_front();
      check_val("abort_cmd_word", cmd_dat, exp);
      @(negedge clk);
      cmd_rdy = 1'b0;
      rx_vld  = 1'b1;
      #1;
      check_val("abort_rx_rdy", 128'(rx_rdy), 128'(1));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("abort_busy", 128'(busy), 128'(0));
      check_val("abort_rx_rdy_low", 128'(rx_rdy), 128'(0));
      check_val("abort_isa_vld", 128'(isa_vld), 128'(0));
      $display("reset during ISA_RX");
      @(negedge clk);
      rst_n  = 1'b0;
      rx_vld = 1'b0;
      #1;
      serve_isa(2, 16'd0, 8'd2, 0, -1, 6'b000000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
